// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver with valid/ready byte output and error pulses.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_deserializer #(
    parameter int ClockFrequency  = 12_000_000,
    parameter int DesiredBaudRate = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int BitCycles  = (ClockFrequency + DesiredBaudRate / 2) / DesiredBaudRate;
    localparam int HalfCycles = BitCycles / 2;
    localparam int CntW       = $clog2(BitCycles);
    localparam logic [CntW-1:0] BitLoad  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta, rx_s;
    logic            deliver_q, deliver_d;
    logic            ferr_d;
    logic            par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_ok_q, par_ok_d;
    logic perr_d;

    assign par_ok = par_ok_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_ok_q     <= 1'b1;
            parity_err_o <= 1'b0;
        end else begin
            par_ok_q     <= par_ok_d;
            parity_err_o <= perr_d;
        end
    end
`else
    assign par_ok       = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_s        <= rx_meta;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            frame_err_o <= ferr_d;
            overrun_o   <= 1'b0;
            // A consumer taking the old byte frees room for the new one
            if (deliver_q) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d  = par_ok_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HalfLoad;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = BitLoad;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = BitLoad;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_ok_d = (rx_s == ^shift_q);
                    cnt_d    = BitLoad;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d   = S_IDLE;
                        deliver_d = par_ok;
`ifdef UART_RX_PARITY_EN
                        perr_d    = !par_ok;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            // Line held low after a bad stop must rise before a new start counts
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
